// File: rtl/network_sim_pkg.sv
// Shared types and constants for the Boolean network simulation core.
// Optional trace outputs are enabled by defining NETWORK_SIM_TRACE_EN.
package network_sim_pkg;

  typedef enum logic [1:0] {
    RANDOM      = 2'd0,
    ROUND_ROBIN = 2'd1,
    SYNC        = 2'd2
  } sim_mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PICK      = 3'd1,
    APPLY     = 3'd2,
    ROUND_END = 3'd3,
    FINISH    = 3'd4
  } sim_state_e;

  // Galois mask for taps 64,63,61,60 in right-shift form
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    logic [63:0] nxt;
    nxt = v >> 1;
    if (v[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/network_sim_if.sv
// Host/control and network_logic bundle for network_sim_core.
// Trace signals exist only when NETWORK_SIM_TRACE_EN is defined.
interface network_sim_if #(
  parameter int RULES     = 16,
  parameter int LOG_RULES = 4,
  parameter int ROUND_W   = 10,
  parameter int STABLE_W  = 4
);
  logic                 start;
  logic [1:0]           mode;
  logic [63:0]          seed;
  logic [RULES-1:0]     init_state;
  logic [ROUND_W-1:0]   max_rounds;
  logic [STABLE_W-1:0]  stable_rounds;
  logic                 clamp_we;
  logic [LOG_RULES-1:0] clamp_sel;
  logic                 clamp_val;
  logic                 clamp_clr;
  logic [RULES-1:0]     logic_out;
  logic [RULES-1:0]     network_state;
  logic                 busy;
  logic                 done;
  logic                 steady_state;
  logic                 timeout;
  logic [ROUND_W-1:0]   round_number;
`ifdef NETWORK_SIM_TRACE_EN
  logic                 trace_valid;
  logic [RULES-1:0]     trace_state;
`endif

  modport master (
    output start, mode, seed, init_state, max_rounds, stable_rounds,
           clamp_we, clamp_sel, clamp_val, clamp_clr, logic_out,
    input  network_state, busy, done, steady_state, timeout, round_number
`ifdef NETWORK_SIM_TRACE_EN
    , input trace_valid, trace_state
`endif
  );

  modport slave (
    input  start, mode, seed, init_state, max_rounds, stable_rounds,
           clamp_we, clamp_sel, clamp_val, clamp_clr, logic_out,
    output network_state, busy, done, steady_state, timeout, round_number
`ifdef NETWORK_SIM_TRACE_EN
    , output trace_valid, trace_state
`endif
  );

endinterface

// File: rtl/order_rng.sv
// 64-bit Galois LFSR that supplies candidate rule indices for random order.
// A zero seed is replaced by INIT_SEED so the register never locks up.
module order_rng
  import network_sim_pkg::*;
#(
  parameter int          LOG_RULES = 4,
  parameter logic [63:0] INIT_SEED = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [63:0]          seed,
  input  logic                 en,
  output logic [LOG_RULES-1:0] cand
);
  logic [63:0] lfsr_r;

  // Seed load on run start, otherwise advance once per enabled cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r <= INIT_SEED;
    end else if (load) begin
      lfsr_r <= (seed == 64'd0) ? INIT_SEED : seed;
    end else if (en) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign cand = lfsr_r[LOG_RULES-1:0];

endmodule

// File: rtl/network_sim_core.sv
// Boolean network update core: holds state, applies network_logic results in
// random, round-robin or synchronous order, with clamps and stop criteria.
// Optional trace outputs are enabled by defining NETWORK_SIM_TRACE_EN.
module network_sim_core
  import network_sim_pkg::*;
#(
  parameter int          RULES     = 16,
  parameter int          LOG_RULES = 4,
  parameter int          ROUND_W   = 10,
  parameter int          STABLE_W  = 4,
  parameter logic [63:0] INIT_SEED = DEFAULT_SEED
) (
  input logic          clk,
  input logic          rst,
  network_sim_if.slave bus
);
  localparam int CAND_N = 1 << LOG_RULES;

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_PICK      = PICK;
  localparam logic [2:0] ST_APPLY     = APPLY;
  localparam logic [2:0] ST_ROUND_END = ROUND_END;
  localparam logic [2:0] ST_FINISH    = FINISH;

  localparam logic [1:0] M_RANDOM = RANDOM;
  localparam logic [1:0] M_RR     = ROUND_ROBIN;
  localparam logic [1:0] M_SYNC   = SYNC;

  localparam logic [RULES-1:0]     RULE_ONE   = {{(RULES-1){1'b0}}, 1'b1};
  localparam logic [ROUND_W-1:0]   ROUND_ONE  = {{(ROUND_W-1){1'b0}}, 1'b1};
  localparam logic [STABLE_W-1:0]  STABLE_ONE = {{(STABLE_W-1){1'b0}}, 1'b1};
  localparam logic [LOG_RULES-1:0] IDX_ONE    = {{(LOG_RULES-1){1'b0}}, 1'b1};
  localparam logic [LOG_RULES-1:0] RR_LAST    = LOG_RULES'(RULES - 1);

  function automatic logic [RULES-1:0] apply_clamp(input logic [RULES-1:0] v,
                                                   input logic [RULES-1:0] m,
                                                   input logic [RULES-1:0] c);
    return (v & ~m) | (m & c);
  endfunction

  logic [RULES-1:0]     state_r, cmask_r, cval_r, upd_r, snap_r;
  logic [2:0]           fsm_r;
  logic [1:0]           mode_r;
  logic [ROUND_W-1:0]   round_r, max_r;
  logic [STABLE_W-1:0]  stable_r, thr_r;
  logic [LOG_RULES-1:0] idx_r, rr_r, cand_s;
  logic                 busy_r, done_r, steady_r, timeout_r;

  logic [RULES-1:0]     cstate_s, clogic_s, sel_s, csel_s, upd_next_s;
  logic [CAND_N-1:0]    drawn_s;
  logic [ROUND_W-1:0]   round_next_s;
  logic [STABLE_W-1:0]  stable_next_s, thr_eff_s;
  logic                 stop_steady_s, stop_limit_s, rng_load_s, rng_en_s;

  assign cstate_s = apply_clamp(state_r, cmask_r, cval_r);
  assign clogic_s = apply_clamp(bus.logic_out, cmask_r, cval_r);

  // One-hot selectors, draw filter and round-end bookkeeping
  always_comb begin
    sel_s      = RULE_ONE << idx_r;
    csel_s     = RULE_ONE << bus.clamp_sel;
    upd_next_s = upd_r | sel_s;
    // Indices beyond RULES read as already drawn so they force a redraw
    drawn_s             = '1;
    drawn_s[RULES-1:0]  = upd_r;
    if (round_r == {ROUND_W{1'b1}}) begin
      round_next_s = round_r;
    end else begin
      round_next_s = round_r + ROUND_ONE;
    end
    if (cstate_s != snap_r) begin
      stable_next_s = '0;
    end else if (stable_r == {STABLE_W{1'b1}}) begin
      stable_next_s = stable_r;
    end else begin
      stable_next_s = stable_r + STABLE_ONE;
    end
    if (thr_r == '0) begin
      thr_eff_s = STABLE_ONE;
    end else begin
      thr_eff_s = thr_r;
    end
    stop_steady_s = (stable_next_s >= thr_eff_s);
    stop_limit_s  = (max_r != '0) && (round_next_s == max_r);
    rng_load_s    = (fsm_r == ST_IDLE) && bus.start;
    rng_en_s      = (fsm_r == ST_PICK) && (mode_r == M_RANDOM);
  end

  order_rng #(
    .LOG_RULES (LOG_RULES),
    .INIT_SEED (INIT_SEED)
  ) u_order_rng (
    .clk  (clk),
    .rst  (rst),
    .load (rng_load_s),
    .seed (bus.seed),
    .en   (rng_en_s),
    .cand (cand_s)
  );

  // Clamp table: writable only while idle, clear has priority over write
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmask_r <= '0;
      cval_r  <= '0;
    end else if (fsm_r == ST_IDLE) begin
      if (bus.clamp_clr) begin
        cmask_r <= '0;
        cval_r  <= '0;
      end else if (bus.clamp_we) begin
        cmask_r <= cmask_r | csel_s;
        cval_r  <= bus.clamp_val ? (cval_r | csel_s) : (cval_r & ~csel_s);
      end
    end
  end

  // Run sequencing: start, pick order, apply, round-end evaluation, finish
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_r     <= ST_IDLE;
      state_r   <= '0;
      upd_r     <= '0;
      snap_r    <= '0;
      mode_r    <= M_RANDOM;
      round_r   <= '0;
      max_r     <= '0;
      stable_r  <= '0;
      thr_r     <= '0;
      idx_r     <= '0;
      rr_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      steady_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r   <= bus.init_state;
            snap_r    <= apply_clamp(bus.init_state, cmask_r, cval_r);
            upd_r     <= '0;
            round_r   <= '0;
            stable_r  <= '0;
            rr_r      <= '0;
            mode_r    <= (bus.mode == 2'd3) ? M_SYNC : bus.mode;
            max_r     <= bus.max_rounds;
            thr_r     <= bus.stable_rounds;
            steady_r  <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b1;
            fsm_r     <= ST_PICK;
          end
        end
        ST_PICK: begin
          case (mode_r)
            M_RANDOM: begin
              if (!drawn_s[cand_s]) begin
                idx_r <= cand_s;
                fsm_r <= ST_APPLY;
              end
            end
            M_RR: begin
              idx_r <= rr_r;
              rr_r  <= (rr_r == RR_LAST) ? '0 : rr_r + IDX_ONE;
              fsm_r <= ST_APPLY;
            end
            default: fsm_r <= ST_APPLY;
          endcase
        end
        ST_APPLY: begin
          if (mode_r == M_SYNC) begin
            state_r <= clogic_s;
            upd_r   <= '1;
            fsm_r   <= ST_ROUND_END;
          end else begin
            // Single-bit update; the next pick sees this new state
            state_r <= (state_r & ~sel_s) | (clogic_s & sel_s);
            upd_r   <= upd_next_s;
            fsm_r   <= (&upd_next_s) ? ST_ROUND_END : ST_PICK;
          end
        end
        ST_ROUND_END: begin
          round_r  <= round_next_s;
          stable_r <= stable_next_s;
          snap_r   <= cstate_s;
          upd_r    <= '0;
          if (stop_steady_s) begin
            steady_r <= 1'b1;
            done_r   <= 1'b1;
            fsm_r    <= ST_FINISH;
          end else if (stop_limit_s) begin
            timeout_r <= 1'b1;
            done_r    <= 1'b1;
            fsm_r     <= ST_FINISH;
          end else begin
            fsm_r <= ST_PICK;
          end
        end
        ST_FINISH: begin
          busy_r <= 1'b0;
          fsm_r  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          fsm_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.network_state = cstate_s;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.steady_state  = steady_r;
  assign bus.timeout       = timeout_r;
  assign bus.round_number  = round_r;

`ifdef NETWORK_SIM_TRACE_EN
  logic [RULES-1:0] trace_hold_r;

  // Remember the last round-end snapshot so trace_state holds between rounds
  always_ff @(posedge clk) begin
    if (!rst) begin
      trace_hold_r <= '0;
    end else if (fsm_r == ST_ROUND_END) begin
      trace_hold_r <= cstate_s;
    end else begin
      trace_hold_r <= trace_hold_r;
    end
  end

  assign bus.trace_valid = (fsm_r == ST_ROUND_END);
  assign bus.trace_state = (fsm_r == ST_ROUND_END) ? cstate_s : trace_hold_r;
`endif

endmodule

// File: tb/tb_network_sim_core.sv
// Directed self-checking bench for network_sim_core (RULES=4 and RULES=5 instances).
module tb_network_sim_core;

  logic       clk;
  logic       rst;
  logic [1:0] fn4;
  int         total;
  int         bad;

  network_sim_if #(.RULES(4), .LOG_RULES(2)) b4 ();
  network_sim_if #(.RULES(5), .LOG_RULES(4)) b5 ();

  network_sim_core #(.RULES(4), .LOG_RULES(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  network_sim_core #(.RULES(5), .LOG_RULES(4)) dut5 (.clk(clk), .rst(rst), .bus(b5));

  always #5 clk = ~clk;

  // Stand-in network_logic: 0 identity, 1 rotate-left, 2 all zeros, 3 invert
  always_comb begin
    case (fn4)
      2'd0:    b4.logic_out = b4.network_state;
      2'd1:    b4.logic_out = {b4.network_state[2:0], b4.network_state[3]};
      2'd2:    b4.logic_out = 4'b0000;
      default: b4.logic_out = ~b4.network_state;
    endcase
  end

  assign b5.logic_out = ~b5.network_state;

  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    if (v[0]) return (v >> 1) ^ 64'hD800_0000_0000_0000;
    else      return v >> 1;
  endfunction

  task automatic run4(input logic [1:0] m, input logic [3:0] init, input logic [9:0] maxr,
                      input logic [3:0] stab, input logic poke, output int cyc);
    @(negedge clk);
    b4.mode = m; b4.init_state = init; b4.max_rounds = maxr;
    b4.stable_rounds = stab; b4.seed = 64'd0; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    b4.clamp_we = poke; b4.clamp_sel = 2'd1; b4.clamp_val = 1'b1;
    cyc = 1;
    total++;
    if (b4.busy !== 1'b1) begin bad++; $display("FAIL busy_in_run: got %b want 1", b4.busy); end
    while (b4.done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      b4.clamp_we = 1'b0;
      cyc++;
    end
    total++;
    if (b4.done !== 1'b1) begin bad++; $display("FAIL done_seen: no done within %0d cycles", cyc); end
    @(negedge clk);
    total++;
    if (b4.done !== 1'b0 || b4.busy !== 1'b0) begin
      bad++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", b4.done, b4.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b4.start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", b4.busy, b4.done);
    end
    total++;
    if (b4.steady_state !== 1'b0 || b4.timeout !== 1'b0 || b4.round_number !== 10'd0) begin
      bad++; $display("FAIL reset_status: steady=%b timeout=%b round=%0d want 0 0 0",
                      b4.steady_state, b4.timeout, b4.round_number);
    end
    total++;
    if (b4.network_state !== 4'b0000 || b5.network_state !== 5'b00000) begin
      bad++; $display("FAIL reset_state: got %b/%b want 0000/00000", b4.network_state, b5.network_state);
    end
    b4.start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_sync_identity();
    int cyc;
    fn4 = 2'd0;
    run4(2'd2, 4'b1010, 10'd0, 4'd1, 1'b0, cyc);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL sync_latency: got %0d want 4", cyc); end
    total++;
    if (b4.steady_state !== 1'b1 || b4.timeout !== 1'b0) begin
      bad++; $display("FAIL sync_flags: steady=%b timeout=%b want 1 0", b4.steady_state, b4.timeout);
    end
    total++;
    if (b4.round_number !== 10'd1) begin bad++; $display("FAIL sync_rounds: got %0d want 1", b4.round_number); end
    total++;
    if (b4.network_state !== 4'b1010) begin bad++; $display("FAIL sync_state: got %b want 1010", b4.network_state); end
  endtask

  task automatic test_round_robin();
    int cyc;
    fn4 = 2'd1;
    run4(2'd1, 4'b0001, 10'd3, 4'd15, 1'b0, cyc);
    total++;
    if (cyc !== 28) begin bad++; $display("FAIL rr_latency: got %0d want 28", cyc); end
    total++;
    if (b4.timeout !== 1'b1 || b4.steady_state !== 1'b0) begin
      bad++; $display("FAIL rr_flags: timeout=%b steady=%b want 1 0", b4.timeout, b4.steady_state);
    end
    total++;
    if (b4.round_number !== 10'd3) begin bad++; $display("FAIL rr_rounds: got %0d want 3", b4.round_number); end
    total++;
    if (b4.network_state !== 4'b0000) begin bad++; $display("FAIL rr_state: got %b want 0000", b4.network_state); end
  endtask

  task automatic test_random();
    logic [63:0] lf;
    logic [3:0]  cand;
    logic [4:0]  prev, diff, cov;
    bit          seen[5];
    int          exp_seq[10], obs_seq[10];
    int          draws, k, got, nobs, multi, cyc, ci, fidx;
    // Reference pick order from a private model of the seed-1 LFSR
    lf = 64'h1; draws = 0; k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) seen[i] = 1'b0;
      got = 0;
      while (got < 5) begin
        cand = lf[3:0]; lf = lfsr_next(lf); draws++;
        ci = int'(cand);
        if (ci < 5) begin
          if (!seen[ci]) begin seen[ci] = 1'b1; exp_seq[k] = ci; k++; got++; end
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      b5.seed = (s == 0) ? 64'd0 : 64'h1;
      b5.mode = 2'd0; b5.init_state = 5'd0; b5.max_rounds = 10'd2;
      b5.stable_rounds = 4'd1; b5.start = 1'b1;
      @(negedge clk);
      b5.start = 1'b0;
      cyc = 1; prev = b5.network_state; nobs = 0; multi = 0;
      for (int i = 0; i < 10; i++) obs_seq[i] = -1;
      while (b5.done !== 1'b1 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        diff = b5.network_state ^ prev;
        prev = b5.network_state;
        if (diff != 5'd0) begin
          if ($countones(diff) != 1) multi++;
          fidx = 0;
          for (int b = 0; b < 5; b++) if (diff[b]) fidx = b;
          if (nobs < 10) obs_seq[nobs] = fidx;
          nobs++;
        end
      end
      total++;
      if (b5.done !== 1'b1) begin bad++; $display("FAIL rnd_done[%0d]: no done within %0d cycles", s, cyc); end
      total++;
      if (cyc !== draws + 13) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", s, cyc, draws + 13); end
      total++;
      if (nobs !== 10 || multi !== 0) begin
        bad++; $display("FAIL rnd_updates[%0d]: got %0d flips (%0d multi-bit) want 10 (0)", s, nobs, multi);
      end
      for (int i = 0; i < 10; i++) begin
        total++;
        if (obs_seq[i] !== exp_seq[i]) begin
          bad++; $display("FAIL rnd_order[%0d][%0d]: got %0d want %0d", s, i, obs_seq[i], exp_seq[i]);
        end
      end
      for (int r = 0; r < 2; r++) begin
        cov = 5'd0;
        for (int i = 0; i < 5; i++) if (obs_seq[r*5+i] >= 0) cov[obs_seq[r*5+i]] = 1'b1;
        total++;
        if (cov !== 5'b11111) begin bad++; $display("FAIL rnd_cover[%0d][%0d]: got %b want 11111", s, r, cov); end
      end
      total++;
      if (b5.timeout !== 1'b1 || b5.steady_state !== 1'b0 || b5.round_number !== 10'd2) begin
        bad++; $display("FAIL rnd_status[%0d]: timeout=%b steady=%b round=%0d want 1 0 2",
                        s, b5.timeout, b5.steady_state, b5.round_number);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    fn4 = 2'd2;
    @(negedge clk); b4.clamp_we = 1'b1; b4.clamp_sel = 2'd2; b4.clamp_val = 1'b1;
    @(negedge clk); b4.clamp_sel = 2'd0; b4.clamp_val = 1'b0;
    @(negedge clk); b4.clamp_we = 1'b0;
    // A clamp write to rule 1 is attempted one cycle into the run
    run4(2'd2, 4'b0000, 10'd0, 4'd1, 1'b1, cyc);
    total++;
    if (b4.network_state !== 4'b0100) begin bad++; $display("FAIL clamp_state: got %b want 0100", b4.network_state); end
    total++;
    if (b4.steady_state !== 1'b1 || b4.round_number !== 10'd1) begin
      bad++; $display("FAIL clamp_status: steady=%b round=%0d want 1 1", b4.steady_state, b4.round_number);
    end
    // Clear together with a write: clear must win
    @(negedge clk); b4.clamp_clr = 1'b1; b4.clamp_we = 1'b1; b4.clamp_sel = 2'd3; b4.clamp_val = 1'b1;
    @(negedge clk); b4.clamp_clr = 1'b0; b4.clamp_we = 1'b0;
    run4(2'd2, 4'b0000, 10'd0, 4'd1, 1'b0, cyc);
    total++;
    if (b4.network_state !== 4'b0000) begin bad++; $display("FAIL clamp_clear: got %b want 0000", b4.network_state); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    fn4 = 2'd3;
    @(negedge clk);
    b4.mode = 2'd0; b4.init_state = 4'b0110; b4.max_rounds = 10'd0;
    b4.stable_rounds = 4'd1; b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: busy=%b done=%b want 0 0", b4.busy, b4.done);
    end
    total++;
    if (b4.network_state !== 4'b0000 || b4.round_number !== 10'd0) begin
      bad++; $display("FAIL midrst_state: state=%b round=%0d want 0000 0", b4.network_state, b4.round_number);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (b4.done !== 1'b0) begin bad++; $display("FAIL midrst_nodone: got %b want 0", b4.done); end
    fn4 = 2'd0;
    run4(2'd2, 4'b0011, 10'd0, 4'd1, 1'b0, cyc);
    total++;
    if (cyc !== 4 || b4.steady_state !== 1'b1 || b4.network_state !== 4'b0011) begin
      bad++; $display("FAIL midrst_rerun: cyc=%0d steady=%b state=%b want 4 1 0011",
                      cyc, b4.steady_state, b4.network_state);
    end
  endtask

  task automatic test_steady_and_limit();
    int cyc;
    fn4 = 2'd0;
    // Mode 3 behaves as synchronous
    run4(2'd3, 4'b0110, 10'd1, 4'd1, 1'b0, cyc);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL both_latency: got %0d want 4", cyc); end
    total++;
    if (b4.steady_state !== 1'b1 || b4.timeout !== 1'b0) begin
      bad++; $display("FAIL both_flags: steady=%b timeout=%b want 1 0", b4.steady_state, b4.timeout);
    end
    total++;
    if (b4.round_number !== 10'd1) begin bad++; $display("FAIL both_rounds: got %0d want 1", b4.round_number); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; fn4 = 2'd0; total = 0; bad = 0;
    b4.start = 1'b0; b4.mode = 2'd0; b4.seed = 64'd0; b4.init_state = 4'd0;
    b4.max_rounds = 10'd0; b4.stable_rounds = 4'd0; b4.clamp_we = 1'b0;
    b4.clamp_sel = 2'd0; b4.clamp_val = 1'b0; b4.clamp_clr = 1'b0;
    b5.start = 1'b0; b5.mode = 2'd0; b5.seed = 64'd0; b5.init_state = 5'd0;
    b5.max_rounds = 10'd0; b5.stable_rounds = 4'd0; b5.clamp_we = 1'b0;
    b5.clamp_sel = 4'd0; b5.clamp_val = 1'b0; b5.clamp_clr = 1'b0;
    test_reset();
    test_sync_identity();
    test_round_robin();
    test_random();
    test_clamp();
    test_reset_mid_run();
    test_steady_and_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
